// File: rtl/tdpu_psum_requant_pkg.sv
// Shared constants and types for the partial-sum requantizer and its output FIFO.
package tdpu_psum_requant_pkg;

  localparam int ACC_WIDTH  = 40;
  localparam int TILE_CNT_W = 8;
  localparam int OUT_MAX    = 127;
  localparam int OUT_MIN    = -128;

  typedef enum logic {RQ_IDLE, RQ_RUN} rq_state_t;

  typedef struct packed {
    logic [TILE_CNT_W-1:0] num_tiles;
    logic [15:0]           scale;
    logic [4:0]            shift;
    logic                  relu_en;
  } requant_cfg_t;

endpackage

// File: rtl/tdpu_out_fifo.sv
// Synchronous first-word-fall-through FIFO; the head reads as zero while empty.
module tdpu_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = i_push & (~o_full | do_pop);
  assign o_data  = o_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/tdpu_psum_requant.sv
// Accumulates K-tile partial sums, requantizes each element to int8 and buffers results.
module tdpu_psum_requant #(
  parameter int PSUM_WIDTH = 32,
  parameter int ACC_WIDTH  = tdpu_psum_requant_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH  = 8,
  parameter int TILE_CNT_W = tdpu_psum_requant_pkg::TILE_CNT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_cfg_valid,
  input  logic [TILE_CNT_W-1:0] i_num_tiles,
  input  logic [15:0]           i_scale,
  input  logic [4:0]            i_shift,
  input  logic                  i_relu_en,
  input  logic                  i_psum_valid,
  input  logic [PSUM_WIDTH-1:0] i_psum,
  output logic                  o_busy,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [OUT_WIDTH-1:0]  o_out_data,
  output logic                  o_overflow
);

  import tdpu_psum_requant_pkg::*;

  localparam int PROD_W = ACC_WIDTH + 16;
  localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(OUT_MAX);
  localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(OUT_MIN);

  rq_state_t                    state_q;
  rq_state_t                    state_d;
  requant_cfg_t                 cfg;
  logic [TILE_CNT_W-1:0]        tile_cnt;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  a_acc;
  logic signed [ACC_WIDTH-1:0]  psum_ext;
  logic                         acc_done;
  logic                         a_valid;
  logic                         m_valid;
  logic signed [PROD_W-1:0]     m_prod;
  logic signed [PROD_W-1:0]     round_bias;
  logic signed [PROD_W-1:0]     shifted;
  logic signed [PROD_W-1:0]     rectified;
  logic [OUT_WIDTH-1:0]         q_data;
  logic                         take;
  logic                         tile_last;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fifo_pop;
  logic                         soft_rst;

  assign soft_rst  = !rst_n || i_clear;
  assign psum_ext  = {{(ACC_WIDTH-PSUM_WIDTH){i_psum[PSUM_WIDTH-1]}}, i_psum};
  assign take      = (state_q == RQ_RUN) && i_psum_valid;
  assign tile_last = (tile_cnt == cfg.num_tiles - 1'b1);
  assign fifo_pop  = o_out_valid & i_out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RQ_IDLE: if (i_cfg_valid) state_d = RQ_RUN;
      RQ_RUN:  state_d = RQ_RUN;
      default: state_d = RQ_IDLE;
    endcase
  end

  // acc_done marks the cycle the final accumulator value is ready for stage A.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q    <= RQ_IDLE;
      cfg        <= '0;
      tile_cnt   <= '0;
      acc        <= '0;
      acc_done   <= 1'b0;
      a_valid    <= 1'b0;
      a_acc      <= '0;
      m_valid    <= 1'b0;
      m_prod     <= '0;
      o_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RQ_IDLE && i_cfg_valid) begin
        cfg.num_tiles <= (i_num_tiles == '0) ? TILE_CNT_W'(1) : i_num_tiles;
        cfg.scale     <= i_scale;
        cfg.shift     <= i_shift;
        cfg.relu_en   <= i_relu_en;
      end
      acc_done <= take && tile_last;
      if (take) begin
        acc      <= (tile_cnt == '0) ? psum_ext : acc + psum_ext;
        tile_cnt <= tile_last ? '0 : tile_cnt + 1'b1;
      end
      a_valid <= acc_done;
      if (acc_done) a_acc <= acc;
      m_valid <= a_valid;
      if (a_valid) m_prod <= PROD_W'(a_acc) * PROD_W'($signed(cfg.scale));
      if (m_valid && fifo_full && !fifo_pop) o_overflow <= 1'b1;
    end
  end

  // Stage Q: round half up, optional ReLU, then clamp into the int8 range.
  always_comb begin
    round_bias = '0;
    if (cfg.shift != '0) round_bias = PROD_W'(1) <<< (cfg.shift - 5'd1);
    shifted   = (m_prod + round_bias) >>> cfg.shift;
    rectified = (cfg.relu_en && shifted[PROD_W-1]) ? '0 : shifted;
    if (rectified > SAT_HI)      q_data = SAT_HI[OUT_WIDTH-1:0];
    else if (rectified < SAT_LO) q_data = SAT_LO[OUT_WIDTH-1:0];
    else                         q_data = rectified[OUT_WIDTH-1:0];
  end

  tdpu_out_fifo #(
    .WIDTH(OUT_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(i_clear),
    .i_push (m_valid),
    .i_data (q_data),
    .i_pop  (fifo_pop),
    .o_data (o_out_data),
    .o_full (fifo_full),
    .o_empty(fifo_empty)
  );

  assign o_out_valid = ~fifo_empty;
  assign o_busy      = (tile_cnt != '0) || acc_done || a_valid || m_valid;

endmodule

// File: tb/tb_tdpu_psum_requant.sv
// Bench for tdpu_psum_requant: cycle-level reference model plus directed literal expectations.
module tb_tdpu_psum_requant;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_clear;
  logic        i_cfg_valid;
  logic [7:0]  i_num_tiles;
  logic [15:0] i_scale;
  logic [4:0]  i_shift;
  logic        i_relu_en;
  logic        i_psum_valid;
  logic [31:0] i_psum;
  logic        o_busy;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [7:0]  o_out_data;
  logic        o_overflow;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int due;
    int val;
  } pend_t;

  // Reference model state: configuration, running sum, in-flight results and FIFO contents.
  bit     m_run;
  int     m_nt, m_scale, m_shift, m_tile, cyc;
  bit     m_relu, m_ovf;
  longint m_acc;
  pend_t  pend[$];
  int     m_fifo[$];
  int     got[$];
  int     exp_q[$];

  tdpu_psum_requant dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (i_clear),
    .i_cfg_valid (i_cfg_valid),
    .i_num_tiles (i_num_tiles),
    .i_scale     (i_scale),
    .i_shift     (i_shift),
    .i_relu_en   (i_relu_en),
    .i_psum_valid(i_psum_valid),
    .i_psum      (i_psum),
    .o_busy      (o_busy),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_overflow  (o_overflow)
  );

  always #5 clk = ~clk;

  function automatic longint wrap40(input longint x);
    return (x <<< 24) >>> 24;
  endfunction

  function automatic int requant(input longint acc);
    longint v;
    v = acc * longint'(m_scale);
    if (m_shift > 0) v = (v + (longint'(1) <<< (m_shift - 1))) >>> m_shift;
    if (m_relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  always @(posedge clk) begin : model
    longint p;
    cyc++;
    if (!rst_n || i_clear) begin
      m_run = 0; m_tile = 0; m_acc = 0; m_ovf = 0;
      m_nt = 1; m_scale = 0; m_shift = 0; m_relu = 0;
      pend.delete();
      m_fifo.delete();
    end else begin
      if (m_fifo.size() > 0 && i_out_ready) void'(m_fifo.pop_front());
      while (pend.size() > 0 && pend[0].due == cyc) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(pend[0].val);
        else m_ovf = 1;
        void'(pend.pop_front());
      end
      if (!m_run) begin
        if (i_cfg_valid) begin
          m_run   = 1;
          m_nt    = (i_num_tiles == 0) ? 1 : int'(i_num_tiles);
          m_scale = int'($signed(i_scale));
          m_shift = int'(i_shift);
          m_relu  = i_relu_en;
        end
      end else if (i_psum_valid) begin
        p = longint'($signed(i_psum));
        m_acc = (m_tile == 0) ? p : wrap40(m_acc + p);
        m_tile++;
        if (m_tile == m_nt) begin
          m_tile = 0;
          pend.push_back('{cyc + 3, requant(m_acc)});
        end
      end
    end
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("busy", longint'(o_busy), longint'(m_tile != 0 || pend.size() != 0));
      check_output("out_valid", longint'(o_out_valid), longint'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) check_output("out_data", $signed(o_out_data), m_fifo[0]);
      check_output("overflow", longint'(o_overflow), longint'(m_ovf));
      if (o_out_valid && i_out_ready) got.push_back(int'($signed(o_out_data)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_stimulus(input logic [31:0] v);
    i_psum_valid = 1'b1;
    i_psum       = v;
    tick();
    i_psum_valid = 1'b0;
  endtask

  task automatic configure(input int nt, input int scale, input int shift, input bit relu);
    i_cfg_valid = 1'b1;
    i_num_tiles = 8'(nt);
    i_scale     = 16'(scale);
    i_shift     = 5'(shift);
    i_relu_en   = relu;
    tick();
    i_cfg_valid = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic check_got(input string name);
    check_output({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_output(name, (i < got.size()) ? got[i] : -999, exp_q[i]);
    got.delete();
  endtask

  initial begin
    rst_n = 0; i_clear = 0; i_cfg_valid = 0; i_num_tiles = 0; i_scale = 0;
    i_shift = 0; i_relu_en = 0; i_psum_valid = 0; i_psum = 0; i_out_ready = 1;
    tick();
    chk_en = 1'b1;
    check_output("rst_busy", o_busy, 0);
    check_output("rst_valid", o_out_valid, 0);
    check_output("rst_data", o_out_data, 0);
    check_output("rst_ovf", o_overflow, 0);
    tick();
    rst_n = 1;

    // Single-tile passthrough with saturation and three-cycle latency.
    configure(1, 1, 0, 0);
    apply_stimulus(5);
    apply_stimulus(-200);
    apply_stimulus(300);
    check_output("lat_early", o_out_valid, 0);
    tick();
    check_output("lat_ontime", o_out_valid, 1);
    check_output("lat_data", $signed(o_out_data), 5);
    idle(6);
    exp_q = '{5, -128, 127};
    check_got("pass");

    // Four-tile accumulation with rounding shift.
    do_clear();
    configure(4, 3, 2, 0);
    apply_stimulus(10);
    check_output("mt_busy_first", o_busy, 1);
    apply_stimulus(20);
    apply_stimulus(-4);
    apply_stimulus(7);
    idle(2);
    check_output("mt_busy_q", o_busy, 1);
    tick();
    check_output("mt_busy_done", o_busy, 0);
    check_output("mt_data", $signed(o_out_data), 25);
    idle(3);
    exp_q = '{25};
    check_got("multi");

    // ReLU clamp, then negative rounding after reconfiguration.
    do_clear();
    configure(1, 1, 0, 1);
    apply_stimulus(-7);
    idle(5);
    exp_q = '{0};
    check_got("relu");
    do_clear();
    configure(1, 1, 1, 0);
    apply_stimulus(-3);
    idle(5);
    exp_q = '{-1};
    check_got("round_neg");

    // Overflow on a full FIFO without a pop.
    do_clear();
    i_out_ready = 0;
    configure(1, 1, 0, 0);
    for (int v = 1; v <= 5; v++) apply_stimulus(v);
    idle(5);
    check_output("ovf_set", o_overflow, 1);
    i_out_ready = 1;
    idle(6);
    exp_q = '{1, 2, 3, 4};
    check_got("ovf_drain");
    check_output("ovf_sticky", o_overflow, 1);

    // Push into a full FIFO with a simultaneous pop is not a drop.
    do_clear();
    check_output("ovf_cleared", o_overflow, 0);
    i_out_ready = 0;
    configure(1, 1, 0, 0);
    for (int v = 1; v <= 4; v++) apply_stimulus(v);
    apply_stimulus(9);
    idle(2);
    i_out_ready = 1;
    tick();
    i_out_ready = 0;
    check_output("full_pop_ovf", o_overflow, 0);
    i_out_ready = 1;
    idle(6);
    exp_q = '{1, 2, 3, 4, 9};
    check_got("full_pop");

    // Abort mid-element; psums before a new cfg are ignored.
    do_clear();
    configure(4, 1, 0, 0);
    apply_stimulus(1);
    apply_stimulus(2);
    i_clear = 1;
    apply_stimulus(3);
    i_clear = 0;
    check_output("abort_busy", o_busy, 0);
    apply_stimulus(5);
    apply_stimulus(6);
    check_output("abort_ignored", o_busy, 0);
    idle(6);
    exp_q = {};
    check_got("abort");

    // Reset while stage M is valid and the FIFO holds two entries.
    i_out_ready = 0;
    configure(1, 1, 0, 0);
    apply_stimulus(11);
    apply_stimulus(12);
    apply_stimulus(13);
    idle(2);
    check_output("pre_rst_valid", o_out_valid, 1);
    rst_n = 0;
    tick();
    check_output("mid_rst_busy", o_busy, 0);
    check_output("mid_rst_valid", o_out_valid, 0);
    check_output("mid_rst_data", o_out_data, 0);
    check_output("mid_rst_ovf", o_overflow, 0);
    rst_n = 1;
    i_out_ready = 1;
    idle(6);
    exp_q = {};
    check_got("post_rst");

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tdpu_psum_requant.md
Name: tdpu_psum_requant

Overview:
- Downstream consumer of the ternary vector core's 32-bit dot-product stream (result plus result-valid).
- Accumulates a configured number of consecutive partial sums (K-tiles of 16) into one output element.
- Requantizes each element to signed 8-bit: multiply by scale, rounding right shift, optional ReLU, saturation.
- Results are buffered in a small output FIFO with a valid/ready handshake. The feeding core cannot be stalled, so overflow is flagged, never back-pressured.

Parameters:
- PSUM_WIDTH, 32, width of incoming partial sum (signed).
- ACC_WIDTH, 40, accumulator width (signed, wraps two's complement).
- OUT_WIDTH, 8, requantized output width (signed).
- TILE_CNT_W, 8, width of the tile-count config field.
- FIFO_DEPTH, 4, output FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_clear  in  1  synchronous abort: return to IDLE, flush everything.
- i_cfg_valid  in  1  config strobe, honoured in IDLE only.
- i_num_tiles  in  TILE_CNT_W  partial sums per output; 0 treated as 1.
- i_scale  in  16  signed multiplier.
- i_shift  in  5  arithmetic right-shift amount, 0..31.
- i_relu_en  in  1  clamp negatives to 0 before saturation.
- i_psum_valid  in  1  partial-sum strobe (core's result-valid).
- i_psum  in  PSUM_WIDTH  signed partial sum.
- o_busy  out  1  accumulation or pipeline in flight.
- o_out_valid  out  1  FIFO not empty.
- i_out_ready  in  1  consumer accepts head.
- o_out_data  out  OUT_WIDTH  signed FIFO head.
- o_overflow  out  1  sticky: a result was dropped on a full FIFO.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset state: state IDLE; accumulator, tile counter, pipeline and FIFO pointers all zero. Outputs o_busy=0, o_out_valid=0, o_out_data=0, o_overflow=0. Reset mid-operation discards everything.
- i_clear: same effect as reset, and has priority over every other input in the same cycle. A psum arriving in that cycle is discarded.
- FSM IDLE -> RUN: on i_cfg_valid, latch num_tiles (0 becomes 1), scale, shift and relu. In IDLE, i_psum_valid is ignored, including in the cfg cycle itself.
- FSM in RUN: i_cfg_valid is ignored. The only exits are i_clear and reset.
- Accumulation: each i_psum_valid sign-extends i_psum to ACC_WIDTH.
  - First tile (tile_cnt==0): acc is loaded with the extended psum.
  - Later tiles: acc is added to.
  - tile_cnt wraps to 0 after num_tiles-1.
  - Back-to-back valids every cycle are supported with no bubbles.
- Pipeline, with the last psum of an element sampled at edge t:
  - Edge t+1, stage A: final acc registered.
  - Edge t+2, stage M: signed product acc*scale, ACC_WIDTH+16 bits.
  - Edge t+3, stage Q: rounding, ReLU and saturation applied, result pushed to the FIFO. o_out_valid rises after edge t+3 if the FIFO was empty.
- Rounding: if shift>0, compute (prod + 2^(shift-1)) >>> shift; if shift==0, prod passes unchanged. Then, if relu, negatives become 0. Finally saturate to [-128,127].
- FIFO: first-word-fall-through.
  - Pop on o_out_valid & i_out_ready.
  - Push while full with a simultaneous pop: legal, no drop.
  - Push while full without a pop: value dropped, o_overflow set until clear or reset.
  - Pop while empty: no effect.
- o_busy: high whenever tile_cnt!=0 or any of stages A/M/Q holds a valid element. FIFO contents do not count.

Decomposition:
- Additions to package_def:
  - ACC_WIDTH constant.
  - requant_cfg_t packed struct (num_tiles, scale, shift, relu_en).
  - rq_state_t enum {RQ_IDLE, RQ_RUN}.
  - Saturation bounds OUT_MAX=127, OUT_MIN=-128.
- One natural sub-module: tdpu_out_fifo, a parameterised sync FWFT FIFO with full/empty flags and synchronous active-low reset/clear.

Test Plan:
- Single-tile passthrough: cfg num_tiles=1, scale=1, shift=0, relu=0; psums 5, -200, 300 on consecutive cycles -> outputs 5, -128, 127, the first visible 3 cycles after its psum; o_overflow=0.
- Multi-tile with rounding: cfg num_tiles=4, scale=3, shift=2; psums 10, 20, -4, 7 -> one output 25 (33*3=99, (99+2)>>>2); o_busy high from the first psum until stage Q empties.
- ReLU and negative rounding: relu=1, num_tiles=1, scale=1, shift=0, psum -7 -> 0. Then clear, reconfigure relu=0, shift=1; psum -3 -> -1.
- Backpressure and overflow: FIFO_DEPTH=4, i_out_ready=0, five single-tile results 1..5 -> o_overflow=1, then ready=1 drains 1, 2, 3, 4 only. A full FIFO with ready=1 in the push cycle -> no drop.
- Abort: num_tiles=4, two psums, then i_clear together with a third psum -> o_busy=0 next cycle, FSM in IDLE, no output. Psums before a new cfg are ignored.
- Reset mid-pipeline: rst_n low while stage M is valid and the FIFO holds 2 entries -> all outputs zero after the edge; no output after release.
